// File: rtl/pkt_fifo_pkg.sv
// Shared types and helpers for the pkt_fifo store-and-forward packet buffer.
package pkt_fifo_pkg;

  typedef enum logic [1:0] {
    WrSync,
    WrAccept,
    WrDrop
  } wr_state_e;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int unsigned ptr_w(input int unsigned depth_log2);
    return depth_log2 + 1;
  endfunction

  // A stored beat is {eof, dat}.
  function automatic int unsigned beat_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/pkt_fifo_ram.sv
// Simple dual-port RAM, synchronous write, registered read; maps to LUTRAM or BRAM.
module pkt_fifo_ram #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned AW    = 6
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [1 << AW];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pkt_fifo.sv
// Store-and-forward packet FIFO: a packet is released only after a clean eof; errored or
// oversized packets are rewound whole. Define PKT_FIFO_STATS_EN to build the packet counters.
module pkt_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_dat,
  input  logic              in_eof,
  input  logic              in_err,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_dat,
  output logic              out_eof,
  input  logic              out_ack,
  output logic              drop,
  output logic [31:0]       rx_pkt_cnt,
  output logic [31:0]       drop_cnt
);

  localparam int unsigned PW    = ptr_w(DEPTH_LOG2);
  localparam int unsigned BW    = beat_w(DATA_W);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef struct packed {
    logic              eof;
    logic [DATA_W-1:0] dat;
  } beat_t;

  wr_state_e       r_state;
  logic [PW-1:0]   r_wr_ptr, r_wr_commit, r_rd_ptr;
  logic            r_drop, r_out_vld;
  logic [PW-1:0]   w_fill;
  logic            w_full, w_we, w_commit, w_drop_evt, w_avail, w_load;
  beat_t           w_wr_beat, w_rd_beat;

  assign w_fill    = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_fill == PW'(DEPTH));
  assign w_wr_beat = '{eof: in_eof, dat: in_dat};

  always_comb begin
    w_we       = 1'b0;
    w_commit   = 1'b0;
    w_drop_evt = 1'b0;
    if (in_vld) begin
      case (r_state)
        WrAccept: begin
          if (w_full) begin
            w_drop_evt = in_eof;
          end else begin
            w_we       = 1'b1;
            w_commit   = in_eof & ~in_err;
            w_drop_evt = in_eof & in_err;
          end
        end
        WrDrop:  w_drop_evt = in_eof;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= WrSync;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_drop <= w_drop_evt;
      // Drop rewinds to the last committed packet boundary.
      if (w_drop_evt)  r_wr_ptr <= r_wr_commit;
      else if (w_we)   r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_commit)    r_wr_commit <= r_wr_ptr + PW'(1);
      if (in_vld) begin
        case (r_state)
          WrSync:   if (in_eof) r_state <= WrAccept;
          WrAccept: if (w_full && !in_eof) r_state <= WrDrop;
          WrDrop:   if (in_eof) r_state <= WrAccept;
          default:  r_state <= WrSync;
        endcase
      end
    end
  end

  // The RAM read register doubles as the output register, so a load is the read.
  assign w_avail = (r_rd_ptr != r_wr_commit);
  assign w_load  = w_avail && (!r_out_vld || out_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_out_vld <= 1'b0;
    end else if (w_load) begin
      r_rd_ptr  <= r_rd_ptr + PW'(1);
      r_out_vld <= 1'b1;
    end else if (out_ack) begin
      r_out_vld <= 1'b0;
    end
  end

  pkt_fifo_ram #(
    .WIDTH (BW),
    .AW    (DEPTH_LOG2)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
    .i_wdata (w_wr_beat),
    .i_re    (w_load),
    .i_raddr (r_rd_ptr[DEPTH_LOG2-1:0]),
    .o_rdata (w_rd_beat)
  );

  assign out_vld = r_out_vld;
  assign out_dat = r_out_vld ? w_rd_beat.dat : '0;
  assign out_eof = r_out_vld & w_rd_beat.eof;
  assign drop    = r_drop;

`ifdef PKT_FIFO_STATS_EN
  logic [31:0] r_rx_pkt_cnt, r_drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_pkt_cnt <= '0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_commit)   r_rx_pkt_cnt <= r_rx_pkt_cnt + 32'd1;
      if (w_drop_evt) r_drop_cnt   <= r_drop_cnt + 32'd1;
    end
  end

  assign rx_pkt_cnt = r_rx_pkt_cnt;
  assign drop_cnt   = r_drop_cnt;
`else
  assign rx_pkt_cnt = '0;
  assign drop_cnt   = '0;
`endif

endmodule

// File: tb/tb_pkt_fifo.sv
// Directed bench for pkt_fifo: frame table plus hand-written full, wrap and reset sequences.
module tb_pkt_fifo;

  localparam int unsigned DATA_W     = 4;
  localparam int unsigned DEPTH_LOG2 = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_vld = 1'b0;
  logic [DATA_W-1:0] in_dat = '0;
  logic              in_eof = 1'b0;
  logic              in_err = 1'b0;
  logic              out_vld;
  logic [DATA_W-1:0] out_dat;
  logic              out_eof;
  logic              out_ack = 1'b0;
  logic              drop;
  logic [31:0]       rx_pkt_cnt;
  logic [31:0]       drop_cnt;

  pkt_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .in_dat     (in_dat),
    .in_eof     (in_eof),
    .in_err     (in_err),
    .out_vld    (out_vld),
    .out_dat    (out_dat),
    .out_eof    (out_eof),
    .out_ack    (out_ack),
    .drop       (drop),
    .rx_pkt_cnt (rx_pkt_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int drops_seen = 0;
  int exp_rx = 0;
  int exp_drop = 0;
  bit rand_ack = 1'b0;
  bit ack_fix = 1'b0;
  bit hold = 1'b0;
  logic [DATA_W:0] hold_beat;
  logic [DATA_W:0] cap[$];
  logic [DATA_W:0] exp_q[$];

  typedef struct {
    int len;
    int base;
    bit err;
    bit pass;
    int exp_drops;
    int exp_beats;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ack = rand_ack ? 1'($urandom_range(0, 1)) : ack_fix;
  end

  // Output monitor: capture accepted beats, count drop pulses, check hold stability.
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_vld", 32'(out_vld), 32'd1);
        check("hold_beat", 32'({out_eof, out_dat}), 32'(hold_beat));
      end
      hold      = out_vld && !out_ack;
      hold_beat = {out_eof, out_dat};
      if (out_vld && out_ack) cap.push_back({out_eof, out_dat});
      if (drop) drops_seen++;
    end
  end

  task automatic send_beat(input logic [DATA_W-1:0] d, input bit eof, input bit err);
    @(posedge clk);
    #1;
    in_vld = 1'b1;
    in_dat = d;
    in_eof = eof;
    in_err = err;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_vld = 1'b0;
      in_eof = 1'b0;
      in_err = 1'b0;
    end
  endtask

  task automatic send_frame(input int len, input int base, input bit err, input bit pass);
    for (int i = 0; i < len; i++) begin
      send_beat(DATA_W'(base + i), i == len - 1, err && (i == len - 1));
      if (pass) exp_q.push_back({1'(i == len - 1), DATA_W'(base + i)});
    end
  endtask

  task automatic send_rand_frame(input int len);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < len; i++) begin
      d = DATA_W'($urandom);
      send_beat(d, i == len - 1, 1'b0);
      exp_q.push_back({1'(i == len - 1), d});
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (cap.size() < exp_q.size() && n < budget) begin
      idle(1);
      n++;
    end
    idle(3);
  endtask

  task automatic compare_q(input string name);
    int n;
    check({name, "_len"}, 32'(cap.size()), 32'(exp_q.size()));
    n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(name, 32'(cap[i]), 32'(exp_q[i]));
    cap.delete();
    exp_q.delete();
  endtask

  task automatic check_ctrs(input string name);
`ifdef PKT_FIFO_STATS_EN
    check({name, "_rx_cnt"}, rx_pkt_cnt, 32'(exp_rx));
    check({name, "_drop_cnt"}, drop_cnt, 32'(exp_drop));
`else
    check({name, "_rx_cnt"}, rx_pkt_cnt, 32'd0);
    check({name, "_drop_cnt"}, drop_cnt, 32'd0);
`endif
  endtask

  initial begin
    int d0, c0, lat, n;

    tbl[0] = '{len: 6,  base: 2,  err: 1'b1, pass: 1'b0, exp_drops: 1, exp_beats: 0};
    tbl[1] = '{len: 4,  base: 9,  err: 1'b0, pass: 1'b1, exp_drops: 0, exp_beats: 4};
    tbl[2] = '{len: 70, base: 0,  err: 1'b0, pass: 1'b0, exp_drops: 1, exp_beats: 0};
    tbl[3] = '{len: 3,  base: 5,  err: 1'b0, pass: 1'b1, exp_drops: 0, exp_beats: 3};
    tbl[4] = '{len: 1,  base: 12, err: 1'b1, pass: 1'b0, exp_drops: 1, exp_beats: 0};
    tbl[5] = '{len: 1,  base: 15, err: 1'b0, pass: 1'b1, exp_drops: 0, exp_beats: 1};

    #3;
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_dat", 32'(out_dat), 32'd0);
    check("rst_out_eof", 32'(out_eof), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check_ctrs("rst");
    ack_fix = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // First frame after reset is swallowed by the sync state.
    send_frame(10, 0, 1'b0, 1'b0);
    idle(14);
    check("sync_beats", 32'(cap.size()), 32'd0);
    check("sync_drops", 32'(drops_seen), 32'd0);

    // Latency: eof in cycle N, first valid in cycle N+2.
    send_frame(10, 0, 1'b0, 1'b1);
    exp_rx++;
    @(negedge clk);
    lat = 0;
    while (!out_vld && lat < 20) begin
      @(posedge clk);
      #1;
      in_vld = 1'b0;
      in_eof = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd2);
    idle(1);
    wait_drain(40);
    compare_q("lat_frame");
    check_ctrs("lat");

    for (int t = 0; t < 6; t++) begin
      d0 = drops_seen;
      c0 = cap.size();
      send_frame(tbl[t].len, tbl[t].base, tbl[t].err, tbl[t].pass);
      idle(tbl[t].len + 8);
      check($sformatf("tbl%0d_drops", t), 32'(drops_seen - d0), 32'(tbl[t].exp_drops));
      check($sformatf("tbl%0d_beats", t), 32'(cap.size() - c0), 32'(tbl[t].exp_beats));
      exp_rx += int'(tbl[t].pass);
      exp_drop += tbl[t].exp_drops;
    end
    compare_q("tbl_data");
    check_ctrs("tbl");

    // Fill: frames 1 and 2 commit, frame 3 overflows and drops on its eof.
    ack_fix = 1'b0;
    idle(3);
    d0 = drops_seen;
    send_frame(30, 1, 1'b0, 1'b1);
    send_frame(30, 7, 1'b0, 1'b1);
    send_frame(30, 3, 1'b0, 1'b0);
    idle(4);
    check("full_drops", 32'(drops_seen - d0), 32'd1);
    check("full_held", 32'(cap.size()), 32'd0);
    ack_fix = 1'b1;
    idle(75);
    exp_rx += 2;
    exp_drop += 1;
    compare_q("full_data");
    check_ctrs("full");

    // Wrap: 200 committed frames with random backpressure.
    d0 = drops_seen;
    rand_ack = 1'b1;
    for (int f = 0; f < 200; f++) begin
      n = 0;
      while ((exp_q.size() - cap.size()) > 50 && n < 500) begin
        idle(1);
        n++;
      end
      send_rand_frame(int'($urandom_range(1, 8)));
    end
    idle(1);
    wait_drain(3000);
    rand_ack = 1'b0;
    idle(3);
    exp_rx += 200;
    check("wrap_drops", 32'(drops_seen - d0), 32'd0);
    compare_q("wrap_data");
    check_ctrs("wrap");

    // Reset with a packet in the output register and a partial frame in flight.
    ack_fix = 1'b0;
    idle(3);
    send_frame(8, 4, 1'b0, 1'b0);
    idle(4);
    check("pre_rst_vld", 32'(out_vld), 32'd1);
    send_beat(DATA_W'(1), 1'b0, 1'b0);
    send_beat(DATA_W'(2), 1'b0, 1'b0);
    send_beat(DATA_W'(3), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_vld = 1'b0;
    #1;
    check("mid_rst_vld", 32'(out_vld), 32'd0);
    check("mid_rst_dat", 32'(out_dat), 32'd0);
    check("mid_rst_eof", 32'(out_eof), 32'd0);
    check("mid_rst_drop", 32'(drop), 32'd0);
    cap.delete();
    exp_q.delete();
    exp_rx = 0;
    exp_drop = 0;
    ack_fix = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    d0 = drops_seen;
    send_beat(DATA_W'(4), 1'b0, 1'b0);
    send_beat(DATA_W'(5), 1'b0, 1'b0);
    send_beat(DATA_W'(6), 1'b1, 1'b0);
    idle(4);
    check("post_rst_tail", 32'(cap.size()), 32'd0);
    send_frame(5, 10, 1'b0, 1'b1);
    exp_rx = 1;
    idle(1);
    wait_drain(40);
    check("post_rst_drops", 32'(drops_seen - d0), 32'd0);
    compare_q("post_rst_data");
    check_ctrs("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
